// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address,
// and registers the fetched word into the IF/ID boundary. A two-state FSM
// parks fetch on a HALT word until a branch redirects it.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_stall,
  input  logic        if_branch_taken,
  input  logic [15:0] if_branch_target,
  input  logic [15:0] if_instruction,
  output logic [15:0] if_from_pc,
  output logic [15:0] id_instruction,
  output logic [15:0] id_pc_plus2,
  output logic        id_valid,
  output logic        if_halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  // PC is halfword aligned; bit 0 of the reset value is dropped too
  localparam logic [15:0] RESET_PC_ALIGNED = RESET_PC & 16'hFFFE;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] id_instr_q, id_instr_d;
  logic [15:0] id_pc2_q, id_pc2_d;
  logic        id_valid_q, id_valid_d;
  logic [15:0] pc_plus2;

  // Wraps modulo 2^16 naturally from the 16-bit add
  assign pc_plus2 = pc_q + 16'd2;

  // Next-state: branch beats stall beats normal/halt fetch
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc2_d   = id_pc2_q;
    id_valid_d = id_valid_q;
    if (if_branch_taken) begin
      pc_d       = {if_branch_target[15:1], 1'b0};
      id_instr_d = 16'h0000;
      id_valid_d = 1'b0;
      state_d    = RUN;
    end else if (if_stall) begin
      // everything holds
    end else begin
      unique case (state_q)
        RUN: begin
          id_pc2_d   = pc_plus2;
          id_valid_d = 1'b1;
          if (if_instruction == HALT_WORD) begin
            // HALT is passed down once; PC parks on the HALT address
            id_instr_d = HALT_WORD;
            state_d    = HALTED;
          end else begin
            id_instr_d = if_instruction;
            pc_d       = pc_plus2;
          end
        end
        HALTED: begin
          id_instr_d = 16'h0000;
          id_valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State and IF/ID registers, async active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC_ALIGNED;
      id_instr_q <= 16'h0000;
      id_pc2_q   <= 16'h0000;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc2_q   <= id_pc2_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign if_from_pc     = pc_q;
  assign id_instruction = id_instr_q;
  assign id_pc_plus2    = id_pc2_q;
  assign id_valid       = id_valid_q;
  assign if_halted      = (state_q == HALTED);

endmodule
